// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Parametrised ALU with valid/ready handshake, registered result
//             and N/Z/C/V flags. Eight ops including a WIDTH-step shift-add
//             multiply.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SHR = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, neg_q, neg_d;
    logic               carry_q, carry_d, ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;

    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_load;

    assign w_shamt = b[SHW-1:0];

    // Single-cycle ALU for every op except MUL; carry/ovf come from the
    // widened intermediate so the shifted-out bit lands in a fixed position.
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        w_diff = {1'b0, a} - {1'b0, b};
        w_shl  = {1'b0, a} << w_shamt;
        w_shr  = {a, 1'b0} >> w_shamt;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            c_OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign w_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_load    = 1'b0;

        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: begin
                acc_d    = w_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{SHW{1'b0}}, 1'b1};
                if (int'(cnt_q) == WIDTH - 1) begin
                    state_d  = S_DONE;
                    result_d = w_acc_nxt[WIDTH-1:0];
                    carry_d  = 1'b0;
                    ovf_d    = |w_acc_nxt[2*WIDTH-1:WIDTH];
                    w_load   = 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance from IDLE or back-to-back from DONE.
        if (in_valid && in_ready) begin
            if (op == c_OP_MUL) begin
                state_d  = S_BUSY;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
            end else begin
                state_d  = S_DONE;
                result_d = w_res;
                carry_d  = w_c;
                ovf_d    = w_v;
                w_load   = 1'b1;
            end
        end

        if (w_load) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[WIDTH-1];
        end
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq (WIDTH=4 and WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic       iv4, ir4, ov4, or4, z4, n4, c4, v4;
    logic [3:0] a4, b4, res4;
    logic [2:0] op4;

    logic       iv8, ir8, ov8, or8, z8, n8, c8, v8;
    logic [7:0] a8, b8, res8;
    logic [2:0] op8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4), .result(res4),
        .zero(z4), .neg(n4), .carry(c4), .ovf(v4)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8),
        .zero(z8), .neg(n8), .carry(c8), .ovf(v8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for WIDTH=8 non-MUL ops: returns {z,n,c,v,res}.
    function automatic logic [11:0] model8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int xi, yi, xs, ys, r, s;
        logic c, v;
        logic [7:0] r8;
        xi = int'(x); yi = int'(y);
        xs = (xi > 127) ? xi - 256 : xi;
        ys = (yi > 127) ? yi - 256 : yi;
        s  = yi % 8;
        c  = 1'b0; v = 1'b0; r = 0;
        case (o)
            3'd0: begin r = xi + yi; c = (r > 255); v = ((xs + ys) > 127) || ((xs + ys) < -128); end
            3'd1: begin r = xi - yi; c = (xi < yi); v = ((xs - ys) > 127) || ((xs - ys) < -128); end
            3'd2: r = xi & yi;
            3'd3: r = xi | yi;
            3'd4: r = xi ^ yi;
            3'd5: begin r = xi << s; c = (s == 0) ? 1'b0 : ((xi >> (8 - s)) & 1) != 0; end
            3'd6: begin r = xi >> s; c = (s == 0) ? 1'b0 : ((xi >> (s - 1)) & 1) != 0; end
            default: r = 0;
        endcase
        r8 = r[7:0];
        return {(r8 == 8'd0), r8[7], c, v, r8};
    endfunction

    task automatic run4(input string tag, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] er, input logic [3:0] ef);
        op4 = o; a4 = x; b4 = y; iv4 = 1'b1; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        chk({tag, "_valid"}, 32'(ov4), 32'd1);
        chk({tag, "_res"}, 32'(res4), 32'(er));
        chk({tag, "_flags"}, 32'({z4, n4, c4, v4}), 32'(ef));
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef);
        op8 = o; a8 = x; b8 = y; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        chk({tag, "_valid"}, 32'(ov8), 32'd1);
        chk({tag, "_res"}, 32'(res8), 32'(er));
        chk({tag, "_flags"}, 32'({z8, n8, c8, v8}), 32'(ef));
    endtask

    task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef);
        int edges;
        op8 = 3'b111; a8 = x; b8 = y; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;   // must be ignored after capture
        edges = 1;
        chk({tag, "_busy_ready"}, 32'(ir8), 32'd0);
        chk({tag, "_busy_valid"}, 32'(ov8), 32'd0);
        while (ov8 !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd9);
        chk({tag, "_res"}, 32'(res8), 32'(er));
        chk({tag, "_flags"}, 32'({z8, n8, c8, v8}), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_q[$];
        logic [11:0] e;
        logic [2:0]  ro;
        logic [7:0]  ra, rb;

        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst4_ready", 32'(ir4), 32'd1);
        chk("rst4_valid", 32'(ov4), 32'd0);
        chk("rst8_ready", 32'(ir8), 32'd1);
        chk("rst8_valid", 32'(ov8), 32'd0);
        chk("rst8_res",   32'(res8), 32'd0);
        chk("rst8_flags", 32'({z8, n8, c8, v8}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // WIDTH=4 legacy vectors, flags are {zero,neg,carry,ovf}
        run4("add4",   3'd0, 4'b0101, 4'b0011, 4'b1000, 4'b0101);
        run4("sub4",   3'd1, 4'b1010, 4'b0101, 4'b0101, 4'b0001);
        run4("and4",   3'd2, 4'b1100, 4'b1010, 4'b1000, 4'b0100);
        run4("or4",    3'd3, 4'b0011, 4'b0101, 4'b0111, 4'b0000);
        run4("add4z",  3'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000);

        // WIDTH=8 shifts and borrow
        run8("shl1",   3'd5, 8'h81, 8'd1, 8'h02, 4'b0010);
        run8("shr0",   3'd6, 8'h81, 8'd0, 8'h81, 4'b0100);
        run8("shr1",   3'd6, 8'h81, 8'd1, 8'h40, 4'b0010);
        run8("sub8",   3'd1, 8'h00, 8'h01, 8'hFF, 4'b0110);
        @(negedge clk);

        // Multiply
        mul8("mul13x11", 8'd13, 8'd11, 8'h8F, 4'b0100);
        mul8("mul16x17", 8'd16, 8'd17, 8'h10, 4'b0001);
        @(negedge clk);

        // Backpressure: 0x70+0x20 = 0x90, neg and signed overflow
        op8 = 3'd0; a8 = 8'h70; b8 = 8'h20; iv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        op8 = 3'd4; a8 = 8'hF0; b8 = 8'h3C;   // XOR waiting behind the stall
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(ov8), 32'd1);
            chk("bp_ready", 32'(ir8), 32'd0);
            chk("bp_res",   32'(res8), 32'h90);
            chk("bp_flags", 32'({z8, n8, c8, v8}), 32'b0101);
            @(negedge clk);
        end
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ir8), 32'd1);
        @(negedge clk);
        iv8 = 1'b0;
        chk("b2b_xor_valid", 32'(ov8), 32'd1);
        chk("b2b_xor_res",   32'(res8), 32'hCC);
        chk("b2b_xor_flags", 32'({z8, n8, c8, v8}), 32'b0100);
        @(negedge clk);

        // Streaming: one non-MUL op per cycle with out_ready held high
        or8 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                chk("stream_valid", 32'(ov8), 32'd1);
                chk("stream_out",   32'({z8, n8, c8, v8, res8}), 32'(e));
            end
            if (i < 16) begin
                ro = 3'($urandom_range(0, 6));
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                op8 = ro; a8 = ra; b8 = rb; iv8 = 1'b1;
                exp_q.push_back(model8(ro, ra, rb));
            end else begin
                iv8 = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_drained", 32'(ov8), 32'd0);

        // Reset during the third multiply step
        op8 = 3'b111; a8 = 8'd13; b8 = 8'd11; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(ir8), 32'd1);
        chk("mrst_valid", 32'(ov8), 32'd0);
        chk("mrst_res",   32'(res8), 32'd0);
        chk("mrst_flags", 32'({z8, n8, c8, v8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_no_result", 32'(ov8), 32'd0);
        run8("post_rst_add", 3'd0, 8'h01, 8'h02, 8'h03, 4'b0000);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
